instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Fetch stage of the pipelined, cached TSC CPU. Owns the program counter and issues read requests to the instruction cache over a ready handshake. Buffers one fetched instruction and presents it, with its PC+1, to the IF/ID pipeline register. Handles redirects from later stages; an optional branch target buffer predicts the next PC.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: first fetch address after reset.
- `BTB_ENTRIES`, default 4: BTB depth, power of two, 2–16. Used only when the BTB is compiled in.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: hazard unit holds IF/ID; the buffered instruction is not consumed.
- `redirect` in 1: a later stage resolved a misprediction or jump; refetch from `redirect_pc`.
- `redirect_pc` in 16: redirect target.
- `i_readM` out 1: instruction read request.
- `i_address` out 16: request address; equals the internal PC.
- `i_data` in 16: fetched word; valid when `i_ready`=1.
- `i_ready` in 1: one-cycle completion pulse from the cache.
- `pc_out` out 16: fetch address + 1 of the buffered instruction.
- `instruction_out` out 16: buffered instruction, or `INVALID_INSTRUCTION` when the buffer is empty.
- `predicted_taken` out 1: BTB hit was used for this instruction's successor.
- `stall_mem` out 1: equals !buffer_valid; drives IF/ID `stall_mem`.
- `btb_update`, `btb_update_pc`[16], `btb_update_target`[16], `btb_update_taken` in: branch resolution from EX.

## Operation
- The state machine has three states:
  - FETCH: request outstanding.
  - HOLD: buffer full, no request.
  - DRAIN: discard an in-flight response.
- Buffer consumed in a cycle when buffer_valid & !stall.
- Request rule: in FETCH, `i_readM`=1 iff (!buffer_valid | consumed) & !redirect. `i_address` is held stable until `i_ready`.
- FETCH, `i_ready`=1, no redirect:
  - buffer ← `i_data`, pc_out ← pc+1, buffer_valid ← 1.
  - pc ← predicted next.
  - Stay in FETCH.
- FETCH, buffer full and not consumed: go to HOLD with `i_readM`=0. HOLD → FETCH on the first cycle the buffer is consumed, and the request is issued in that same cycle.
- Redirect, any state:
  - pc ← `redirect_pc` and buffer_valid ← 0.
  - If a request is outstanding and `i_ready`=0 in that cycle, go to DRAIN; otherwise go to FETCH.
- DRAIN: `i_readM` stays 1 with the old `i_address` until `i_ready`. The response is discarded, then go to FETCH with the new pc.
- A redirect arriving during DRAIN updates pc; the state stays DRAIN.
- `redirect` has priority over `i_ready` and `stall`. A response arriving in the redirect cycle is discarded.
- PC arithmetic is 16-bit modulo: 16'hFFFF + 1 = 16'h0000.

## Timing
- Reset values:
  - pc = `RESET_PC`, state = FETCH, buffer_valid = 0.
  - `instruction_out` = `INVALID_INSTRUCTION`, `pc_out` = 0, `predicted_taken` = 0, `stall_mem` = 1, `i_readM` = 0.
  - All BTB valid bits cleared.
- `i_readM` first rises in the cycle after reset deasserts.
- Latency: data is in the buffer on the edge where `i_ready`=1 is sampled, and is visible to IF/ID in the next cycle.
- Throughput is one instruction per cycle when `i_ready` is high in consecutive cycles and `stall`=0.
- `i_ready` may assert in the first request cycle.
- Reset mid-request: the response is ignored; the cache is reset by the same signal.

## Configuration
- `FETCH_BTB_EN` defined:
  - Next pc = BTB target when the entry indexed by pc[log2(BTB_ENTRIES)-1:0] is valid and its tag matches pc; otherwise pc+1.
  - `predicted_taken` is registered with the buffer.
  - On `btb_update`: taken writes the entry (valid, tag, target); not taken clears valid on a tag match.
  - An update and a lookup to the same entry in the same cycle: the lookup sees the old contents.
- `FETCH_BTB_EN` undefined:
  - Next pc = pc+1 and `predicted_taken` = 0.
  - `btb_*` inputs are ignored and no BTB storage is built.

## Test plan
- Reset, then `i_ready` every cycle, `stall`=0 → addresses 0,1,2,3 on consecutive cycles; `pc_out` 1,2,3,4 one cycle after each response.
- `i_ready` 3 cycles after request → `i_address`=5 held 3 cycles; `stall_mem`=1 until the data is buffered.
- `stall` high 4 cycles with buffer full → `i_readM`=0 (HOLD), outputs frozen; request for the next pc issued in the cycle `stall` falls.
- `redirect` to 16'h0040 while the request for 16'h0010 is pending → DRAIN; the 16'h0010 response is discarded, next request is 16'h0040, `instruction_out`=`INVALID_INSTRUCTION` meanwhile.
- BTB: update pc=16'h0008 → target 16'h0020, then fetch 16'h0008 → next address 16'h0020 and `predicted_taken`=1; not-taken update, refetch → next address 16'h0009.
- pc 16'hFFFF, `i_ready` → next request address 16'h0000; `pc_out`=16'h0000.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, requests words from the I-cache, buffers one instruction for IF/ID.
// Optional branch target buffer compiled in with `define FETCH_BTB_EN.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC            = 16'h0000,
  parameter int          BTB_ENTRIES         = 4,
  parameter logic [15:0] INVALID_INSTRUCTION = 16'hB01C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        i_readM,
  output logic [15:0] i_address,
  input  logic [15:0] i_data,
  input  logic        i_ready,
  output logic [15:0] pc_out,
  output logic [15:0] instruction_out,
  output logic        predicted_taken,
  output logic        stall_mem,
  input  logic        btb_update,
  input  logic [15:0] btb_update_pc,
  input  logic [15:0] btb_update_target,
  input  logic        btb_update_taken
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [15:0] drain_addr_q, drain_addr_d;
  logic        buf_valid_q, buf_valid_d;
  logic        pred_q, pred_d;
  logic        pend_q, pend_d;

  logic        consumed;
  logic        btb_hit;
  logic [15:0] btb_target;
  logic [15:0] pc_plus1;
  logic [15:0] next_pc;

  assign pc_plus1 = pc_q + 16'd1;
  assign consumed = buf_valid_q & ~stall;
  assign next_pc  = btb_hit ? btb_target : pc_plus1;

`ifdef FETCH_BTB_EN
  localparam int IDX_W = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 1;

  logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [15:0]            btb_tag_q    [BTB_ENTRIES];
  logic [15:0]            btb_tag_d    [BTB_ENTRIES];
  logic [15:0]            btb_target_q [BTB_ENTRIES];
  logic [15:0]            btb_target_d [BTB_ENTRIES];
  logic [IDX_W-1:0]       lookup_idx, update_idx;

  assign lookup_idx = pc_q[IDX_W-1:0];
  assign update_idx = btb_update_pc[IDX_W-1:0];
  // Lookup reads the registered contents, so a same-cycle update is seen only next cycle.
  assign btb_hit    = btb_valid_q[lookup_idx] && (btb_tag_q[lookup_idx] == pc_q);
  assign btb_target = btb_target_q[lookup_idx];

  always_comb begin
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (btb_update) begin
      if (btb_update_taken) begin
        btb_valid_d[update_idx]  = 1'b1;
        btb_tag_d[update_idx]    = btb_update_pc;
        btb_target_d[update_idx] = btb_update_target;
      end else if (btb_valid_q[update_idx] && (btb_tag_q[update_idx] == btb_update_pc)) begin
        btb_valid_d[update_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    btb_tag_q    <= btb_tag_d;
    btb_target_q <= btb_target_d;
    if (reset) begin
      btb_valid_q <= '0;
    end else begin
      btb_valid_q <= btb_valid_d;
    end
  end
`else
  logic unused_btb;
  assign unused_btb = ^{btb_update, btb_update_pc, btb_update_target, btb_update_taken};
  assign btb_hit    = 1'b0;
  assign btb_target = pc_plus1;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    pc_out_d     = pc_out_q;
    pred_d       = pred_q;
    drain_addr_d = drain_addr_q;
    i_readM      = 1'b0;
    i_address    = pc_q;

    case (state_q)
      S_DRAIN: begin
        // Keep the abandoned request alive until the cache completes it, then drop the word.
        i_readM   = 1'b1;
        i_address = drain_addr_q;
        if (redirect) pc_d = redirect_pc;
        if (i_ready) state_d = S_FETCH;
      end
      default: begin
        if (consumed) buf_valid_d = 1'b0;
        if (redirect) begin
          pc_d        = redirect_pc;
          buf_valid_d = 1'b0;
          if (pend_q && !i_ready) begin
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end else begin
            state_d = S_FETCH;
          end
        end else if (!buf_valid_q || consumed) begin
          i_readM = 1'b1;
          state_d = S_FETCH;
          if (i_ready) begin
            buf_d       = i_data;
            buf_valid_d = 1'b1;
            pc_out_d    = pc_plus1;
            pred_d      = btb_hit;
            pc_d        = next_pc;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
    endcase

    if (reset) i_readM = 1'b0;
    pend_d = i_readM & ~i_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      buf_q        <= 16'h0000;
      buf_valid_q  <= 1'b0;
      pc_out_q     <= 16'h0000;
      pred_q       <= 1'b0;
      pend_q       <= 1'b0;
      drain_addr_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      pc_out_q     <= pc_out_d;
      pred_q       <= pred_d;
      pend_q       <= pend_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign pc_out          = pc_out_q;
  assign instruction_out = buf_valid_q ? buf_q : INVALID_INSTRUCTION;
  assign predicted_taken = pred_q;
  assign stall_mem       = ~buf_valid_q;

endmodule
